// File: rtl/seq_alu_if.sv
// Operand/op request and result bus between the pipeline and seq_alu.
// The master drives the request side; the slave (the ALU) returns status and result.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [14:0]      alu_bus;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic             gt;
  logic             eq;
  logic             div_by_zero;

  modport master (
    output start, flush, a, b, alu_bus,
    input  busy, done, alu_result, gt, eq, div_by_zero
  );

  modport slave (
    input  start, flush, a, b, alu_bus,
    output busy, done, alu_result, gt, eq, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Clocked SimpleRisc ALU: single-cycle logic/arith ops, iterative shift-add mul and restoring div/mod.
// Optional macro SEQ_ALU_MUL_EARLY_EXIT_EN ends MUL once the remaining multiplier bits are zero.
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   mcand, mcand_d;
  logic [WIDTH-1:0]   mplier, mplier_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   rem, rem_d;
  logic [WIDTH-1:0]   quo, quo_d;
  logic [WIDTH-1:0]   dvsr, dvsr_d;
  logic               neg_q, neg_q_d;
  logic               neg_r, neg_r_d;
  logic               is_mod, is_mod_d;
  logic [SHAMT_W-1:0] cnt, cnt_d;

  logic               op_vld;
  logic [3:0]         op_idx;
  logic [WIDTH-1:0]   mul_sum;
  logic               mul_last;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [SHAMT_W-1:0] shamt;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.alu_result  = result_q;
  assign bus.gt          = gt_q;
  assign bus.eq          = eq_q;
  assign bus.div_by_zero = dbz_q;

  assign shamt = bus.b[SHAMT_W-1:0];

  // Priority decode: lowest set alu_bus bit selects the op
  always_comb begin
    op_vld = 1'b0;
    op_idx = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (bus.alu_bus[i] && !op_vld) begin
        op_vld = 1'b1;
        op_idx = 4'(i);
      end
    end
  end

  // Datapath helpers for one MUL / DIV iteration
  always_comb begin
    mul_sum  = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
    mul_last = (cnt == SHAMT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    mul_last = (cnt == SHAMT_W'(WIDTH - 1));
`endif
    div_sh   = {rem, quo[WIDTH-1]};
    div_diff = div_sh - {1'b0, dvsr};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    dbz_d    = dbz_q;
    mcand_d  = mcand;
    mplier_d = mplier;
    acc_d    = acc;
    rem_d    = rem;
    quo_d    = quo;
    dvsr_d   = dvsr;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    is_mod_d = is_mod;
    cnt_d    = cnt;

    case (state)
      IDLE: begin
        if (bus.start) begin
          done_d = 1'b1;
          if (!op_vld) begin
            result_d = '0;
          end else begin
            case (op_idx)
              4'd0, 4'd13, 4'd14: result_d = bus.a + bus.b;
              4'd1:               result_d = bus.a - bus.b;
              4'd2: begin
                done_d   = 1'b0;
                busy_d   = 1'b1;
                state_d  = MUL;
                mcand_d  = bus.a;
                mplier_d = bus.b;
                acc_d    = '0;
                cnt_d    = '0;
              end
              4'd3, 4'd4: begin
                if (bus.b == '0) begin
                  result_d = (op_idx == 4'd4) ? bus.a : '0;
                  dbz_d    = 1'b1;
                end else begin
                  done_d   = 1'b0;
                  busy_d   = 1'b1;
                  state_d  = DIV;
                  quo_d    = bus.a[WIDTH-1] ? -bus.a : bus.a;
                  dvsr_d   = bus.b[WIDTH-1] ? -bus.b : bus.b;
                  rem_d    = '0;
                  cnt_d    = '0;
                  neg_q_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  neg_r_d  = bus.a[WIDTH-1];
                  is_mod_d = (op_idx == 4'd4);
                end
              end
              4'd5: begin
                result_d = bus.a - bus.b;
                gt_d     = $signed(bus.a) > $signed(bus.b);
                eq_d     = (bus.a == bus.b);
              end
              4'd6:    result_d = bus.a & bus.b;
              4'd7:    result_d = bus.a | bus.b;
              4'd8:    result_d = ~bus.b;
              4'd9:    result_d = bus.b;
              4'd10:   result_d = bus.a << shamt;
              4'd11:   result_d = bus.a >> shamt;
              4'd12:   result_d = $signed(bus.a) >>> shamt;
              default: result_d = '0;
            endcase
          end
        end
      end

      MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        cnt_d    = cnt + 1'b1;
        if (mul_last) begin
          result_d = mul_sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      DIV: begin
        if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          quo_d = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_sh[WIDTH-1:0];
          quo_d = {quo[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt + 1'b1;
        if (cnt == SHAMT_W'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign
        if (is_mod) result_d = neg_r ? -rem : rem;
        else        result_d = neg_q ? -quo : quo;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything except reset; architectural results hold
    if (bus.flush) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      dbz_d    = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      dbz_q    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_mod   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      dbz_q    <= dbz_d;
      mcand    <= mcand_d;
      mplier   <= mplier_d;
      acc      <= acc_d;
      rem      <= rem_d;
      quo      <= quo_d;
      dvsr     <= dvsr_d;
      neg_q    <= neg_q_d;
      neg_r    <= neg_r_d;
      is_mod   <= is_mod_d;
      cnt      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table plus hand-written
// sequences for busy-ignore, flush and back-to-back start.
module tb_seq_alu;
  localparam int unsigned W = 32;

  localparam logic [14:0] OP_ADD = 15'd1 << 0;
  localparam logic [14:0] OP_SUB = 15'd1 << 1;
  localparam logic [14:0] OP_MUL = 15'd1 << 2;
  localparam logic [14:0] OP_DIV = 15'd1 << 3;
  localparam logic [14:0] OP_MOD = 15'd1 << 4;
  localparam logic [14:0] OP_CMP = 15'd1 << 5;
  localparam logic [14:0] OP_AND = 15'd1 << 6;
  localparam logic [14:0] OP_OR  = 15'd1 << 7;
  localparam logic [14:0] OP_NOT = 15'd1 << 8;
  localparam logic [14:0] OP_MOV = 15'd1 << 9;
  localparam logic [14:0] OP_LSL = 15'd1 << 10;
  localparam logic [14:0] OP_LSR = 15'd1 << 11;
  localparam logic [14:0] OP_ASR = 15'd1 << 12;
  localparam logic [14:0] OP_LD  = 15'd1 << 13;
  localparam logic [14:0] OP_ST  = 15'd1 << 14;

`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
  localparam int LAT_MUL_BIG   = 18;
  localparam int LAT_MUL_SEVEN = 4;
`else
  localparam int LAT_MUL_BIG   = 33;
  localparam int LAT_MUL_SEVEN = 33;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string        name;
    logic [14:0]  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
    logic         busy1;
    logic         gt;
    logic         eq;
    logic         chk_dbz;
    logic         dbz;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int passed = 0;

  function automatic vec_t mk(string name, logic [14:0] op, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] res, int lat, logic busy1, logic gt, logic eq,
                              logic chk_dbz, logic dbz);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
    v.busy1 = busy1; v.gt = gt; v.eq = eq; v.chk_dbz = chk_dbz; v.dbz = dbz;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one op and wait (bounded) for done; lat = cycle of done counting the start edge as 0
  task automatic do_op(input logic [14:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat, output logic busy1);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_bus = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy1 = bus.busy;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = bus.alu_result;
    if (!bus.done) lat = -1;
  endtask

  initial begin
    logic [W-1:0] res;
    int           lat;
    logic         busy1;
    logic         saw_done;
    logic         busy_c6, done_c6, busy_c11;

    // Reset with garbage on the inputs
    rst_n = 1'b0;
    bus.start = 1'b1; bus.flush = 1'b0; bus.alu_bus = 15'h7FFF;
    bus.a = 32'hDEADBEEF; bus.b = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    check("reset_busy",   64'(bus.busy), 64'd0);
    check("reset_done",   64'(bus.done), 64'd0);
    check("reset_result", 64'(bus.alu_result), 64'd0);
    check("reset_gt",     64'(bus.gt), 64'd0);
    check("reset_eq",     64'(bus.eq), 64'd0);
    check("reset_dbz",    64'(bus.div_by_zero), 64'd0);
    bus.start = 1'b0; bus.alu_bus = '0;
    @(negedge clk);
    rst_n = 1'b1;

    //                 name          op      a             b             result        lat  busy1 gt eq chkdbz dbz
    vecs.push_back(mk("add",        OP_ADD, 32'd7,        32'd5,        32'd12,        1,          0, 0, 0, 0, 0));
    vecs.push_back(mk("cmp_neg",    OP_CMP, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd2,         1,          0, 1, 0, 0, 0));
    vecs.push_back(mk("or",         OP_OR,  32'hF0,       32'h0F,       32'hFF,        1,          0, 1, 0, 0, 0));
    vecs.push_back(mk("mul_wrap",   OP_MUL, 32'h10000,    32'h10000,    32'h0,         LAT_MUL_BIG, 1, 1, 0, 0, 0));
    vecs.push_back(mk("mul_neg",    OP_MUL, 32'hFFFFFFFA, 32'd7,        32'hFFFFFFD6,  LAT_MUL_SEVEN, 1, 1, 0, 0, 0));
    vecs.push_back(mk("div_neg",    OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  34,         1, 1, 0, 1, 0));
    vecs.push_back(mk("mod_neg",    OP_MOD, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  34,         1, 1, 0, 1, 0));
    vecs.push_back(mk("div_zero",   OP_DIV, 32'd5,        32'd0,        32'd0,         1,          0, 1, 0, 1, 1));
    vecs.push_back(mk("mod_zero",   OP_MOD, 32'd5,        32'd0,        32'd5,         1,          0, 1, 0, 1, 1));
    vecs.push_back(mk("asr_wrap",   OP_ASR, 32'h80000000, 32'h21,       32'hC0000000,  1,          0, 1, 0, 0, 0));
    vecs.push_back(mk("cmp_eq",     OP_CMP, 32'd5,        32'd5,        32'd0,         1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("lsl",        OP_LSL, 32'd1,        32'd31,       32'h80000000,  1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("lsr",        OP_LSR, 32'h80000000, 32'd4,        32'h08000000,  1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("sub",        OP_SUB, 32'd3,        32'd5,        32'hFFFFFFFE,  1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("div_mneg",   OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  34,         1, 0, 1, 1, 0));
    vecs.push_back(mk("mod_mneg",   OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'h0,         34,         1, 0, 1, 1, 0));
    vecs.push_back(mk("div_negb",   OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  34,         1, 0, 1, 1, 0));
    vecs.push_back(mk("mod_negb",   OP_MOD, 32'd7,        32'hFFFFFFFE, 32'd1,         34,         1, 0, 1, 1, 0));
    vecs.push_back(mk("not",        OP_NOT, 32'h12345678, 32'h0F0F0F0F, 32'hF0F0F0F0,  1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("mov",        OP_MOV, 32'hAAAA5555, 32'h1234,     32'h1234,      1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("and",        OP_AND, 32'hFF00,     32'h0FF0,     32'h0F00,      1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("ld_addr",    OP_LD,  32'd100,      32'd4,        32'd104,       1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("st_addr",    OP_ST,  32'd8,        32'hFFFFFFFC, 32'd4,         1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("multi_hot",  OP_SUB | OP_MUL, 32'd10, 32'd3,     32'd7,         1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("no_op",      15'd0,  32'd9,        32'd9,        32'd0,         1,          0, 0, 1, 0, 0));
    vecs.push_back(mk("cmp_signed", OP_CMP, 32'd1,        32'hFFFFFFFF, 32'd2,         1,          0, 1, 0, 0, 0));
    vecs.push_back(mk("cmp_mneg",   OP_CMP, 32'h80000000, 32'h7FFFFFFF, 32'd1,         1,          0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy1);
      check({vecs[i].name, "_result"}, 64'(res), 64'(vecs[i].res));
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_busy1"}, 64'(busy1), 64'(vecs[i].busy1));
      check({vecs[i].name, "_gt"}, 64'(bus.gt), 64'(vecs[i].gt));
      check({vecs[i].name, "_eq"}, 64'(bus.eq), 64'(vecs[i].eq));
      if (vecs[i].chk_dbz) check({vecs[i].name, "_dbz"}, 64'(bus.div_by_zero), 64'(vecs[i].dbz));
    end

    // Known result to watch for holding across ignored start and flush
    do_op(OP_ADD, 32'd7, 32'd5, res, lat, busy1);
    check("seed_result", 64'(res), 64'd12);

    // Mul in flight: start at cycle 5 ignored, flush at cycle 10, start+flush at cycle 20 dropped
    @(negedge clk);
    bus.start = 1'b1; bus.alu_bus = OP_MUL; bus.a = 32'd3; bus.b = 32'h80000001;
    saw_done = 1'b0;
    busy_c6 = 1'b0; done_c6 = 1'b1; busy_c11 = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (c == 6) begin busy_c6 = bus.busy; done_c6 = bus.done; end
      if (c == 11) busy_c11 = bus.busy;
      bus.start = (c == 5) || (c == 20);
      bus.alu_bus = (c == 5 || c == 20) ? OP_ADD : OP_MUL;
      bus.a = 32'd1; bus.b = 32'd1;
      bus.flush = (c == 10) || (c == 20);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    check("ignore_busy_c6", 64'(busy_c6), 64'd1);
    check("ignore_done_c6", 64'(done_c6), 64'd0);
    check("flush_busy_c11", 64'(busy_c11), 64'd0);
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_result_hold", 64'(bus.alu_result), 64'd12);
    check("flush_gt_hold", 64'(bus.gt), 64'd0);
    check("flush_eq_hold", 64'(bus.eq), 64'd0);

    // Back-to-back: new start issued in the cycle done is high
    do_op(OP_MUL, 32'd3, 32'd4, res, lat, busy1);
    check("b2b_first_result", 64'(res), 64'd12);
    check("b2b_first_busy_low", 64'(bus.busy), 64'd0);
    bus.start = 1'b1; bus.alu_bus = OP_ADD; bus.a = 32'd10; bus.b = 32'd20;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_second_done", 64'(bus.done), 64'd1);
    check("b2b_second_result", 64'(bus.alu_result), 64'd30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational SimpleRisc ALU.
- Keeps the 15-bit one-hot alu_bus op encoding, generalised to WIDTH-bit operands.
- Replaces the combinational mul/div/mod with iterative shift-add and restoring-division engines, behind a start/done handshake.
- Sits between the operand-fetch and memory-access stages. The pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand/result width. Power of two, 8..64.
- SHAMT_W, $clog2(WIDTH): shift-amount bits taken from b.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  capture a, b, alu_bus this cycle (accepted only when busy=0)
- flush  in  1  synchronous abort of any in-flight op
- a  in  WIDTH  operand A (two's complement)
- b  in  WIDTH  operand B / immediate
- alu_bus  in  15  one-hot op: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr, 13 ld-addr, 14 st-addr
- busy  out  1  multi-cycle op in flight
- done  out  1  one-cycle pulse; result valid
- alu_result  out  WIDTH  registered result, held until the next done
- gt  out  1  signed a>b from the last cmp
- eq  out  1  a==b from the last cmp
- div_by_zero  out  1  qualifies done: the last div/mod had b==0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, alu_result, gt, eq and div_by_zero all go to 0.
  - Overrides start and flush.
- Decode: if several alu_bus bits are set, the lowest-index bit wins. alu_bus==0 with start gives done next cycle with result 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, single-cycle op (bits 0,1,5-14):
  - Result registered at that edge; done=1 next cycle; busy stays 0.
  - add/ld/st: a+b. sub/cmp: a-b. and/or: bitwise. not: ~b. mov: b.
  - lsl/lsr/asr: shift a by b[SHAMT_W-1:0].
  - All results are mod 2^WIDTH.
  - cmp additionally updates gt (signed) and eq. No other op changes gt or eq.
- IDLE, start=1, mul:
  - Goes to MUL with busy=1.
  - Runs WIDTH shift-add iterations, one multiplier bit per cycle.
  - Result = low WIDTH bits of a*b (sign-agnostic).
  - done in cycle WIDTH+1, counting the start edge as cycle 0; busy drops in the same cycle.
- IDLE, start=1, div/mod:
  - If b==0: done next cycle, alu_result=0 (div) or a (mod), div_by_zero=1, no busy.
  - Otherwise:
    - Absolute values are latched and the FSM goes to DIV.
    - DIV runs WIDTH restoring iterations, then FIX applies signs. done in cycle WIDTH+2.
    - Quotient truncates toward zero; remainder takes the dividend's sign.
    - Most-negative / -1 gives quotient = most-negative, remainder 0. No trap.
    - div_by_zero=0.
- start while busy=1: ignored, no side effects. The caller must hold its request.
- start in the same cycle as done: accepted, because busy is already 0 in that cycle.
- flush=1:
  - Next state is IDLE, busy=0, and no done is produced.
  - alu_result, gt and eq keep their previous values.
  - If start and flush coincide in IDLE, flush wins and the op is dropped.
- alu_result changes only on cycles where done=1.

Optional Feature:
- Macro: SEQ_ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL leaves as soon as the remaining shifted multiplier is zero. done comes in cycle k+1, where k = max(1, index of the highest set bit of b, plus 1). b==0 gives done in cycle 2.
- Undefined: fixed WIDTH+1 latency. Result values are identical either way.

Test Plan:
- Reset with garbage inputs, then add a=7, b=5 -> done at cycle 1, alu_result=12, busy stays 0, gt=eq=0.
- cmp a=-3, b=-5 -> gt=1, eq=0. Then or 0xF0|0x0F -> alu_result=0xFF, gt/eq unchanged.
- mul a=0x10000, b=0x10000 (WIDTH=32) -> result 0, done at cycle 33. mul -6*7 -> 0xFFFFFFD6. With early exit, b=7 -> done at cycle 4.
- div -7/2 -> 0xFFFFFFFD at cycle 34; mod -7,2 -> 0xFFFFFFFF. div 5/0 -> result 0, div_by_zero=1 at cycle 1.
- mul in flight, start add at cycle 5 -> ignored. flush at cycle 10 -> busy=0, no done, alu_result holds its old value.
- asr 0x80000000 by b=0x21 -> shift by 1, result 0xC0000000. Back-to-back start on the done cycle -> accepted.
